fir_tap_sequencer: RTL and testbench

Upstream control/datapath stage of the FIR core that feeds the shared add/multiply ALU. It accepts one input sample per valid/ready handshake and stores it in a circular delay line. For each tap it issues coefficient/sample pairs to the ALU in multiply mode, accumulates the registered products at full width, and emits one saturated 32-bit filter output per input sample.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_delay_line.sv | 48 ++++
 rtl/fir_tap_sequencer.sv | 122 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap sequencer and its ALU interface.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 32;
  localparam int SAT_IN_W = 64;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -64'sh0000_0000_8000_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  // Clamp a sign-extended accumulator into the signed 32-bit output range.
  function automatic logic signed [PROD_W-1:0] sat32(input logic signed [SAT_IN_W-1:0] v);
    if (v > SAT_MAX)
      return 32'sh7FFF_FFFF;
    else if (v < SAT_MIN)
      return 32'sh8000_0000;
    else
      return v[PROD_W-1:0];
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer and coefficient register file; tap_idx 0 reads the newest sample.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter  int NTAPS = 8,
  localparam int IDX_W = $clog2(NTAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       smp_we,
  input  logic signed [SAMPLE_W-1:0] smp_wdata,
  input  logic                       coef_we,
  input  logic        [IDX_W-1:0]    coef_waddr,
  input  logic signed [SAMPLE_W-1:0] coef_wdata,
  input  logic        [IDX_W-1:0]    tap_idx,
  output logic signed [SAMPLE_W-1:0] tap_sample,
  output logic signed [SAMPLE_W-1:0] tap_coef
);

  logic signed [SAMPLE_W-1:0] smp_buf [NTAPS];
  logic signed [SAMPLE_W-1:0] coef_rf [NTAPS];
  logic        [IDX_W-1:0]    wr_ptr;
  logic        [IDX_W-1:0]    rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int k = 0; k < NTAPS; k++) smp_buf[k] <= '0;
    end else if (smp_we) begin
      smp_buf[wr_ptr] <= smp_wdata;
      wr_ptr          <= wr_ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) coef_rf[k] <= '0;
    end else if (coef_we) begin
      coef_rf[coef_waddr] <= coef_wdata;
    end
  end

  // wr_ptr already points past the newest sample; power-of-two depth makes the wrap free.
  assign rd_addr    = wr_ptr - IDX_W'(1) - tap_idx;
  assign tap_sample = smp_buf[rd_addr];
  assign tap_coef   = coef_rf[tap_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Issues sample/coefficient pairs to the shared ALU, accumulates the products and
// emits one saturated 32-bit filter output per accepted input sample.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter  int NTAPS   = 8,
  parameter  int ALU_LAT = 2,
  parameter  int ACC_W   = 40,
  localparam int IDX_W   = $clog2(NTAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       coef_wr_en,
  input  logic        [IDX_W-1:0]    coef_wr_addr,
  input  logic signed [SAMPLE_W-1:0] coef_wr_data,
  output logic        [1:0]          alu_op_sel,
  output logic signed [SAMPLE_W-1:0] alu_a,
  output logic signed [SAMPLE_W-1:0] alu_b,
  input  logic signed [PROD_W-1:0]   alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [PROD_W-1:0]   out_sample,
  output logic                       busy
);

  state_t                     state;
  logic        [IDX_W-1:0]    tap_idx;
  logic        [ALU_LAT-1:0]  vld_p;
  logic signed [ACC_W-1:0]    acc;
  logic                       accept;
  logic                       issuing;
  logic signed [SAMPLE_W-1:0] tap_sample;
  logic signed [SAMPLE_W-1:0] tap_coef;

  assign accept     = in_valid && in_ready;
  assign issuing    = (state == ISSUE);
  assign alu_op_sel = OP_MUL;
  assign alu_a      = issuing ? tap_sample : '0;
  assign alu_b      = issuing ? tap_coef   : '0;

  fir_delay_line #(.NTAPS(NTAPS)) u_delay_line (
    .clk        (clk),
    .rst        (rst),
    .smp_we     (accept),
    .smp_wdata  (in_sample),
    .coef_we    (coef_wr_en && (state == IDLE)),
    .coef_waddr (coef_wr_addr),
    .coef_wdata (coef_wr_data),
    .tap_idx    (tap_idx),
    .tap_sample (tap_sample),
    .tap_coef   (tap_coef)
  );

  // ALU latency stage: vld_p[ALU_LAT-1] marks the cycle a product is on alu_result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issuing;
      for (int k = 1; k < ALU_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Accumulate stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (accept)
      acc <= '0;
    else if (vld_p[ALU_LAT-1])
      acc <= acc + ACC_W'(alu_result);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tap_idx    <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ISSUE;
            tap_idx  <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ISSUE: begin
          if (tap_idx == IDX_W'(NTAPS - 1))
            state <= DRAIN;
          else
            tap_idx <= tap_idx + IDX_W'(1);
        end
        DRAIN: begin
          // An empty pipe means the last product has already been folded into acc.
          if (vld_p == '0) begin
            state      <= OUTPUT;
            out_valid  <= 1'b1;
            out_sample <= sat32(SAT_IN_W'(acc));
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed, table-driven bench for fir_tap_sequencer with a two-stage multiplier model as the ALU.
module tb_fir_tap_sequencer;

  typedef struct {
    logic signed [15:0] smp;
    logic signed [31:0] exp;
    bit                 chk;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_sample = '0;
  logic               coef_wr_en = 1'b0;
  logic        [2:0]  coef_wr_addr = '0;
  logic signed [15:0] coef_wr_data = '0;
  logic        [1:0]  alu_op_sel;
  logic signed [15:0] alu_a;
  logic signed [15:0] alu_b;
  logic signed [31:0] alu_result;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_sample;
  logic               busy;

  logic signed [31:0] alu_p1 = '0;
  logic signed [31:0] alu_p2 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] hist_m [8];
  logic signed [15:0] coef_m [8];
  vec_t               vt [24];

  fir_tap_sequencer #(.NTAPS(8), .ALU_LAT(2), .ACC_W(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .alu_op_sel   (alu_op_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sample   (out_sample),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    alu_p1 <= 32'(alu_a) * 32'(alu_b);
    alu_p2 <= alu_p1;
  end
  assign alu_result = alu_p2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] model_out();
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'(hist_m[k]) * longint'(coef_m[k]);
    if (s > 64'sd2147483647) return 32'sh7FFFFFFF;
    if (s < -64'sd2147483648) return 32'sh80000000;
    return s[31:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      hist_m[k] = '0;
      coef_m[k] = '0;
    end
  endtask

  task automatic write_coef(input int idx, input logic signed [15:0] v);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'(idx);
    coef_wr_data = v;
    @(posedge clk);
    @(negedge clk);
    coef_wr_en = 1'b0;
    coef_m[idx] = v;
  endtask

  task automatic accept(input logic signed [15:0] s);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 7; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = s;
  endtask

  task automatic collect(input int lat0, input int hold,
                         output logic signed [31:0] got, output int lat);
    bit ok = 1'b1;
    lat = lat0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || alu_op_sel !== 2'b01) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    chk("ctl_while_busy", 64'(ok), 64'd1);
    got = out_sample;
    if (hold > 0) begin
      out_ready = 1'b0;
      ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        in_valid  = ~h[0];
        in_sample = 16'sd1234;
        @(negedge clk);
        if (out_valid !== 1'b1 || out_sample !== got || in_ready !== 1'b0 || busy !== 1'b1)
          ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("backpressure_hold", 64'(ok), 64'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic signed [31:0] got;
    int lat;
    accept(v.smp);
    collect(0, 0, got, lat);
    chk({nm, "_latency"}, 64'(lat), 64'd11);
    if (v.chk) chk(nm, 64'(got), 64'(v.exp));
  endtask

  initial begin
    logic signed [31:0] got;
    int lat;
    bit ok;

    for (int k = 0; k < 8; k++) begin
      vt[k]      = '{smp: (k == 0) ? 16'sd1 : 16'sd0, exp: 32'(k + 1), chk: 1'b1};
      vt[8 + k]  = '{smp: 16'sd32767, exp: 32'sh7FFFFFFF, chk: (k == 7)};
      vt[16 + k] = '{smp: -16'sd32768, exp: 32'sh80000000, chk: (k == 7)};
    end
    model_clear();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sample", 64'(out_sample), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_op_sel", 64'(alu_op_sel), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
    for (int k = 0; k < 8; k++) run_vec(vt[k], "impulse");

    for (int k = 0; k < 8; k++) write_coef(k, 16'sd32767);
    for (int k = 8; k < 16; k++) run_vec(vt[k], "sat_pos");
    for (int k = 16; k < 24; k++) run_vec(vt[k], "sat_neg");

    for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
    accept(16'sd10);
    collect(0, 5, got, lat);
    chk("bp_out_hand", 64'(got), 64'(-32'sd1146870));
    chk("bp_out_model", 64'(got), 64'(model_out()));
    accept(16'sd0);
    collect(0, 0, got, lat);
    chk("bp_next_hand", 64'(got), 64'(-32'sd1081324));
    chk("bp_next_model", 64'(got), 64'(model_out()));

    for (int k = 0; k < 8; k++) write_coef(k, (k == 0) ? 16'sd5 : 16'sd0);
    accept(16'sd2);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'd0;
    coef_wr_data = 16'sd100;
    @(negedge clk);
    coef_wr_en = 1'b0;
    collect(1, 0, got, lat);
    chk("coef_issue_latency", 64'(lat), 64'd11);
    chk("coef_issue_out", 64'(got), 64'd10);
    accept(16'sd1);
    collect(0, 0, got, lat);
    chk("coef_issue_ignored", 64'(got), 64'd5);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'd0;
    coef_wr_data = 16'sd100;
    accept(16'sd2);
    coef_wr_en = 1'b0;
    coef_m[0]  = 16'sd100;
    collect(0, 0, got, lat);
    chk("coef_idle_same_cycle", 64'(got), 64'd200);
    chk("coef_idle_model", 64'(got), 64'(model_out()));

    accept(16'sd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sample", 64'(out_sample), 64'd0);
    chk("midrst_alu_a", 64'(alu_a), 64'd0);
    chk("midrst_alu_b", 64'(alu_b), 64'd0);
    chk("midrst_alu_op_sel", 64'(alu_op_sel), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    ok = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("midrst_no_partial", 64'(ok), 64'd1);
    for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
    for (int k = 0; k < 8; k++) run_vec(vt[k], "impulse_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
